pps_drift_tracker: RTL and testbench
====================================

# pps_drift_tracker

Downstream consumer of the PPS drift measurement stage. It takes each 10-second drift report (a signed cycle-count error plus the UTC seconds count) and keeps an 8-deep history of accepted reports. It rejects outliers, publishes a running-average drift for the clock-correction logic, and flags holdover when reports stop arriving.

## Interface
- DRIFT_COUNT_WIDTH, 16, width of the signed drift input and the average output
- UTC_SECONDS_WIDTH, 32, width of the UTC seconds field
- HIST_LOG2, 3, log2 of history depth (depth = 8)
- OUTLIER_THRESH, 64, largest allowed |sample − average| for acceptance, in cycles
- MAX_REJECTS, 3, consecutive rejects that trigger a flush
- TIMEOUT_WIDTH, 40, width of the watchdog counter
- TIMEOUT_CYCLES, 6_758_400_000, cycles without a report before holdover (11 s at 614.4 MHz)
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- drift_ready  in  1  one-cycle strobe; drift_in and utc_in are valid on this cycle
- drift_in  in  DRIFT_COUNT_WIDTH  signed drift sample
- utc_in  in  UTC_SECONDS_WIDTH  UTC seconds tagged to the sample
- avg_drift  out  DRIFT_COUNT_WIDTH  signed average of the history
- avg_utc_seconds  out  UTC_SECONDS_WIDTH  utc_in of the sample that produced avg_drift
- avg_strobe  out  1  one-cycle pulse when avg_drift updates
- locked  out  1  history is full and tracking
- holdover  out  1  watchdog expired; avg_drift is held
- reject_count  out  8  total rejected samples since reset; saturates at 255

## Operation
- State machine has three states: FILL (reset state), TRACK, HOLDOVER.
- History is a circular buffer with depth 2^HIST_LOG2. It has a write pointer, a fill count (0..8), and a running sum of width DRIFT_COUNT_WIDTH+HIST_LOG2.
  - Each insert: sum = sum − evicted entry + new entry. The evicted entry is 0 while not full.
- Average = sum arithmetically shifted right by HIST_LOG2 (floor toward −inf), truncated to DRIFT_COUNT_WIDTH.
- FILL state:
  - Every sample is accepted with no outlier test; avg_strobe is not asserted.
  - When the fill count reaches 8: go to TRACK, set locked=1, issue avg_strobe.
- TRACK state:
  - Compute diff = drift_in − avg_drift at DRIFT_COUNT_WIDTH+1 bits.
  - Accept if |diff| ≤ OUTLIER_THRESH: insert, issue avg_strobe, clear the reject run.
  - Otherwise reject: no insert, reject_count+1, reject run+1.
  - When the reject run reaches MAX_REJECTS, flush:
    - Clear history, sum, fill count and reject run; locked=0; go to FILL.
    - The triggering sample is written as the first entry of the new history.
    - avg_drift is held.
- HOLDOVER state:
  - Entered from TRACK on watchdog expiry; holdover=1, locked=0, avg_drift held.
  - The next sample is tested against the held avg_drift.
  - Accepted: insert, go to TRACK, holdover=0, locked=1, avg_strobe.
  - Rejected: reject_count+1 and flush as above (holdover=0, FILL, sample is first entry).
- Watchdog expiry while in FILL: clear history and fill count; stay in FILL; holdover stays 0.
- Reject run is tracked only in TRACK; HOLDOVER and FILL keep it at 0.

## Timing
- All outputs reset to 0; state resets to FILL; history, sum, pointers and watchdog reset to 0.
- drift_ready on cycle N:
  - The accept/reject decision and history/sum update register at edge N+1.
  - avg_drift, avg_utc_seconds and avg_strobe register at edge N+2.
  - locked and holdover change at edge N+2, together with avg_strobe.
  - reject_count increments at edge N+1.
- Back-to-back strobes on consecutive cycles are all processed. The outlier test uses avg_drift as registered in the sample's own cycle.
- Watchdog:
  - Counter clears on any drift_ready, accepted or rejected; otherwise it increments and saturates.
  - Expiry occurs when the counter equals TIMEOUT_CYCLES−1 with no strobe that cycle; the state change is visible the next cycle.
  - If drift_ready coincides with expiry, the strobe wins and there is no expiry.
- rst asserted mid-operation (including mid-pipeline) drops in-flight samples; there is no avg_strobe after reset.

## Test plan
- Eight strobes with drift_in=100, utc_in=10..80 -> no avg_strobe on the first seven; on the 8th, avg_strobe at N+2 with avg_drift=100, avg_utc_seconds=80, locked=1.
- Locked at avg 100, then drift_in=300 -> no avg_strobe, reject_count=1. Then drift_in=164 -> accepted, avg_drift=108. Then drift_in=36 (|diff| 72) -> rejected.
- Locked at avg 100, then three strobes of 500 -> reject_count=3; locked=0 at N+2 of the third; avg_drift holds 100. Seven more strobes of 500 -> avg_drift=500, locked=1.
- Seven samples of −1 and one of 0 -> avg_drift=−1 (floor). Seven of +1 and one of 0 -> avg_drift=0.
- With TIMEOUT_CYCLES=1000, locked, then no strobe -> holdover=1 exactly 1000 cycles after the last strobe. Sample within threshold -> holdover=0, locked=1, avg_strobe. Repeat with an outlier -> FILL, reject_count+1.
- Assert rst for one cycle between decision and output of a sample -> no avg_strobe; all outputs 0; next eight samples refill normally.

Source files
------------

// File: rtl/pps_drift_tracker.sv
// pps_drift_tracker
//
// Consumes the 10-second PPS drift reports and keeps an 8-deep history of
// accepted samples. Samples that stray too far from the running average are
// rejected, and a run of rejects restarts the history. The running average is
// published for clock correction. When reports stop arriving the block drops
// into holdover.
//
// Ports
//   clk              system clock
//   rst              synchronous, active-high reset
//   drift_ready      one-cycle strobe qualifying drift_in / utc_in
//   drift_in         signed drift sample, in cycles
//   utc_in           UTC seconds tagged to the sample
//   avg_drift        signed average of the history (floor division)
//   avg_utc_seconds  utc_in of the sample that produced avg_drift
//   avg_strobe       one-cycle pulse when avg_drift updates
//   locked           history full and tracking
//   holdover         watchdog expired, avg_drift held
//   reject_count     rejected samples since reset, saturating at 255
//
// Pipeline: decision and history update register one edge after the strobe;
// the published outputs register on the following edge.

module pps_drift_tracker #(
  parameter int DRIFT_COUNT_WIDTH = 16,
  parameter int UTC_SECONDS_WIDTH = 32,
  parameter int HIST_LOG2         = 3,
  parameter int OUTLIER_THRESH    = 64,
  parameter int MAX_REJECTS       = 3,
  parameter int TIMEOUT_WIDTH     = 40,
  parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = 40'd6_758_400_000
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                drift_ready,
  input  logic signed [DRIFT_COUNT_WIDTH-1:0] drift_in,
  input  logic        [UTC_SECONDS_WIDTH-1:0] utc_in,
  output logic signed [DRIFT_COUNT_WIDTH-1:0] avg_drift,
  output logic        [UTC_SECONDS_WIDTH-1:0] avg_utc_seconds,
  output logic                                avg_strobe,
  output logic                                locked,
  output logic                                holdover,
  output logic        [7:0]                   reject_count
);

  localparam int DW    = DRIFT_COUNT_WIDTH;
  localparam int DEPTH = 1 << HIST_LOG2;
  localparam int SUM_W = DW + HIST_LOG2;
  localparam int RUN_W = $clog2(MAX_REJECTS + 1);

  localparam logic [HIST_LOG2:0]       FILL_LAST    = (HIST_LOG2+1)'(DEPTH - 1);
  localparam logic signed [DW:0]       THRESH_S     = (DW+1)'(OUTLIER_THRESH);
  localparam logic [RUN_W-1:0]         RUN_LAST     = RUN_W'(MAX_REJECTS - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_CYCLES - TIMEOUT_WIDTH'(1);

  localparam logic [1:0] ST_FILL  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // Floor average: arithmetic shift rounds toward -inf, then truncate.
  function automatic logic signed [DW-1:0] avg_of(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] sh;
    sh = s >>> HIST_LOG2;
    return sh[DW-1:0];
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // History state
  logic signed [DW-1:0]    hist_q [DEPTH];
  logic [HIST_LOG2-1:0]    wr_ptr_q;
  logic [HIST_LOG2:0]      fill_q;
  logic signed [SUM_W-1:0] sum_q;

  // Control state
  logic [1:0]               state_q;
  logic [RUN_W-1:0]         run_q;
  logic [TIMEOUT_WIDTH-1:0] wdog_q;

  // Decision-stage outputs (p0)
  logic                         vld_p0;
  logic                         stb_p0;
  logic                         locked_p0;
  logic                         hold_p0;
  logic [UTC_SECONDS_WIDTH-1:0] utc_p0;

  logic signed [DW-1:0]    evicted;
  logic signed [SUM_W-1:0] sum_ins;
  logic signed [DW:0]      diff;
  logic                    in_range;
  logic                    wdog_expire;

  logic             do_insert;
  logic             do_flush;
  logic             do_reject;
  logic             do_wipe;
  logic             stb_nxt;
  logic [1:0]       state_nxt;
  logic [RUN_W-1:0] run_nxt;

  // The slot being overwritten only contributes to the sum once the buffer
  // has wrapped; before that it is treated as zero.
  assign evicted     = fill_q[HIST_LOG2] ? hist_q[wr_ptr_q] : '0;
  assign sum_ins     = sum_q - SUM_W'(evicted) + SUM_W'(drift_in);
  assign diff        = (DW+1)'(drift_in) - (DW+1)'(avg_drift);
  assign in_range    = (diff <= THRESH_S) && (diff >= -THRESH_S);
  // A strobe in the expiry cycle wins over the timeout.
  assign wdog_expire = !drift_ready && (wdog_q == TIMEOUT_LAST);

  always_comb begin
    do_insert = 1'b0;
    do_flush  = 1'b0;
    do_reject = 1'b0;
    do_wipe   = 1'b0;
    stb_nxt   = 1'b0;
    state_nxt = state_q;
    run_nxt   = run_q;
    case (state_q)
      ST_FILL: begin
        run_nxt = '0;
        if (drift_ready) begin
          do_insert = 1'b1;
          if (fill_q == FILL_LAST) begin
            state_nxt = ST_TRACK;
            stb_nxt   = 1'b1;
          end
        end else if (wdog_expire) begin
          do_wipe = 1'b1;
        end
      end
      ST_TRACK: begin
        if (drift_ready) begin
          if (in_range) begin
            do_insert = 1'b1;
            stb_nxt   = 1'b1;
            run_nxt   = '0;
          end else begin
            do_reject = 1'b1;
            if (run_q == RUN_LAST) begin
              do_flush  = 1'b1;
              state_nxt = ST_FILL;
              run_nxt   = '0;
            end else begin
              run_nxt = run_q + RUN_W'(1);
            end
          end
        end else if (wdog_expire) begin
          state_nxt = ST_HOLD;
          run_nxt   = '0;
        end
      end
      ST_HOLD: begin
        run_nxt = '0;
        if (drift_ready) begin
          if (in_range) begin
            do_insert = 1'b1;
            stb_nxt   = 1'b1;
            state_nxt = ST_TRACK;
          end else begin
            do_reject = 1'b1;
            do_flush  = 1'b1;
            state_nxt = ST_FILL;
          end
        end
      end
      default: begin
        state_nxt = ST_FILL;
        run_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FILL;
      run_q   <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_nxt;
      run_q   <= run_nxt;
      if (drift_ready)
        wdog_q <= '0;
      else if (wdog_q != '1)
        wdog_q <= wdog_q + TIMEOUT_WIDTH'(1);
    end
  end

  // ---- stage p0: decision registered, history and sum updated ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      sum_q    <= '0;
    end else if (do_flush) begin
      // Restart the history with the sample that triggered the flush.
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      hist_q[0] <= drift_in;
      wr_ptr_q  <= HIST_LOG2'(1);
      fill_q    <= (HIST_LOG2+1)'(1);
      sum_q     <= SUM_W'(drift_in);
    end else if (do_wipe) begin
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      sum_q    <= '0;
    end else if (do_insert) begin
      hist_q[wr_ptr_q] <= drift_in;
      wr_ptr_q         <= wr_ptr_q + HIST_LOG2'(1);
      sum_q            <= sum_ins;
      if (!fill_q[HIST_LOG2]) fill_q <= fill_q + (HIST_LOG2+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0    <= 1'b0;
      stb_p0    <= 1'b0;
      locked_p0 <= 1'b0;
      hold_p0   <= 1'b0;
    end else begin
      vld_p0    <= drift_ready;
      stb_p0    <= stb_nxt;
      locked_p0 <= (state_nxt == ST_TRACK);
      hold_p0   <= (state_nxt == ST_HOLD);
    end
  end

  always_ff @(posedge clk) begin
    utc_p0 <= utc_in;
  end

  // ---- stage p1: published outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      avg_drift       <= '0;
      avg_utc_seconds <= '0;
      avg_strobe      <= 1'b0;
      locked          <= 1'b0;
      holdover        <= 1'b0;
      reject_count    <= '0;
    end else begin
      avg_strobe <= vld_p0 && stb_p0;
      if (vld_p0) begin
        locked   <= locked_p0;
        holdover <= hold_p0;
        if (stb_p0) begin
          avg_drift       <= avg_of(sum_q);
          avg_utc_seconds <= utc_p0;
        end
      end
      // Holdover entry is shown on the edge that takes the state change.
      if (wdog_expire && (state_q == ST_TRACK)) begin
        locked   <= 1'b0;
        holdover <= 1'b1;
      end
      if (do_reject) reject_count <= sat_inc8(reject_count);
    end
  end

endmodule

// File: tb/tb_pps_drift_tracker.sv
module tb_pps_drift_tracker;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               drift_ready = 1'b0;
  logic signed [15:0] drift_in = '0;
  logic [31:0]        utc_in = '0;
  logic signed [15:0] avg_drift;
  logic [31:0]        avg_utc_seconds;
  logic               avg_strobe;
  logic               locked;
  logic               holdover;
  logic [7:0]         reject_count;

  always #5 clk = ~clk;

  pps_drift_tracker #(
    .TIMEOUT_CYCLES(40'd1000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .drift_ready    (drift_ready),
    .drift_in       (drift_in),
    .utc_in         (utc_in),
    .avg_drift      (avg_drift),
    .avg_utc_seconds(avg_utc_seconds),
    .avg_strobe     (avg_strobe),
    .locked         (locked),
    .holdover       (holdover),
    .reject_count   (reject_count)
  );

  typedef struct packed {
    logic signed [15:0] d;
    logic [31:0]        u;
    logic               lk;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every avg_strobe pops one expected entry.
  always @(posedge clk) begin
    #1;
    if (avg_strobe === 1'b1) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe: avg_drift %0d utc %0d, expected no strobe",
                 avg_drift, avg_utc_seconds);
      end else begin
        mon_e = sbq.pop_front();
        chk("sb_avg_drift", 64'(avg_drift), 64'(mon_e.d));
        chk("sb_avg_utc", 64'(avg_utc_seconds), 64'(mon_e.u));
        chk("sb_locked", 64'(locked), 64'(mon_e.lk));
      end
    end
  end

  // One sample; checks the strobe is absent at N+1 and as expected at N+2.
  task automatic send(input int d, input int u, input bit stb, input int exp_avg);
    exp_t e;
    if (stb) begin
      e.d  = 16'(exp_avg);
      e.u  = 32'(u);
      e.lk = 1'b1;
      sbq.push_back(e);
    end
    @(negedge clk);
    drift_ready = 1'b1;
    drift_in    = 16'(d);
    utc_in      = 32'(u);
    @(negedge clk);
    drift_ready = 1'b0;
    chk("strobe_at_n1", 64'(avg_strobe), 64'(0));
    @(negedge clk);
    chk("strobe_at_n2", 64'(avg_strobe), 64'(stb));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_avg_drift"}, 64'(avg_drift), 64'(0));
    chk({tag, "_avg_utc"}, 64'(avg_utc_seconds), 64'(0));
    chk({tag, "_avg_strobe"}, 64'(avg_strobe), 64'(0));
    chk({tag, "_locked"}, 64'(locked), 64'(0));
    chk({tag, "_holdover"}, 64'(holdover), 64'(0));
    chk({tag, "_reject_count"}, 64'(reject_count), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp4 [7];
    exp4 = '{-1, -1, -1, 0, 0, 0, 0};

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Fill with 100: only the eighth sample publishes.
    for (int i = 1; i <= 8; i++) begin
      send(100, i * 10, i == 8, 100);
      if (i == 7) chk("fill_locked_before_full", 64'(locked), 64'(0));
    end
    chk("fill_locked", 64'(locked), 64'(1));

    // Outlier rejection around avg 100.
    send(300, 90, 1'b0, 0);
    chk("rej300_count", 64'(reject_count), 64'(1));
    chk("rej300_locked", 64'(locked), 64'(1));
    send(164, 100, 1'b1, 108);
    send(36, 110, 1'b0, 0);
    chk("rej36_count", 64'(reject_count), 64'(2));
    chk("rej36_avg_held", 64'(avg_drift), 64'(108));

    // Three consecutive rejects flush; refill at 500.
    do_reset();
    for (int i = 1; i <= 8; i++) send(100, 200 + i, i == 8, 100);
    for (int k = 1; k <= 3; k++) begin
      send(500, 300 + k, 1'b0, 0);
      if (k == 2) chk("flush_locked_k2", 64'(locked), 64'(1));
    end
    chk("flush_count", 64'(reject_count), 64'(3));
    chk("flush_locked", 64'(locked), 64'(0));
    chk("flush_avg_held", 64'(avg_drift), 64'(100));
    for (int i = 1; i <= 7; i++) send(500, 310 + i, i == 7, 500);
    chk("refill500_locked", 64'(locked), 64'(1));

    // Floor rounding of negative and small positive sums.
    do_reset();
    for (int i = 1; i <= 7; i++) send(-1, 400 + i, 1'b0, 0);
    send(0, 408, 1'b1, -1);
    for (int i = 0; i < 7; i++) send(1, 410 + i, 1'b1, exp4[i]);
    send(0, 420, 1'b1, 0);
    chk("floor_final_avg", 64'(avg_drift), 64'(0));

    // Watchdog: holdover exactly 1000 edges after the capturing edge.
    begin
      exp_t e;
      e.d  = 16'(0);
      e.u  = 32'(500);
      e.lk = 1'b1;
      sbq.push_back(e);
    end
    @(negedge clk);
    drift_ready = 1'b1;
    drift_in    = 16'(0);
    utc_in      = 32'(500);
    @(posedge clk);
    @(negedge clk);
    drift_ready = 1'b0;
    repeat (999) @(posedge clk);
    #1;
    chk("wdog_holdover_999", 64'(holdover), 64'(0));
    chk("wdog_locked_999", 64'(locked), 64'(1));
    @(posedge clk);
    #1;
    chk("wdog_holdover_1000", 64'(holdover), 64'(1));
    chk("wdog_locked_1000", 64'(locked), 64'(0));
    chk("wdog_avg_held", 64'(avg_drift), 64'(0));

    // In-range sample leaves holdover: sum 6 - 1 + 5 = 10 -> avg 1.
    send(5, 510, 1'b1, 1);
    chk("hold_exit_holdover", 64'(holdover), 64'(0));
    chk("hold_exit_locked", 64'(locked), 64'(1));

    // Expire again, then an outlier flushes back to FILL.
    repeat (1000) @(negedge clk);
    chk("wdog2_holdover", 64'(holdover), 64'(1));
    send(500, 520, 1'b0, 0);
    chk("hold_rej_count", 64'(reject_count), 64'(1));
    chk("hold_rej_holdover", 64'(holdover), 64'(0));
    chk("hold_rej_locked", 64'(locked), 64'(0));
    chk("hold_rej_avg_held", 64'(avg_drift), 64'(1));

    // Reset between decision and output of the filling sample.
    do_reset();
    for (int i = 1; i <= 7; i++) send(20, 600 + i, 1'b0, 0);
    @(negedge clk);
    drift_ready = 1'b1;
    drift_in    = 16'(20);
    utc_in      = 32'(608);
    @(negedge clk);
    drift_ready = 1'b0;
    rst         = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("midrst");
    @(posedge clk);
    #1;
    chk("midrst_no_strobe", 64'(avg_strobe), 64'(0));
    for (int i = 1; i <= 8; i++) send(40, 700 + i, i == 8, 40);
    chk("midrst_refill_locked", 64'(locked), 64'(1));

    repeat (5) @(negedge clk);
    chk("sb_drained", 64'(sbq.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
